// File: rtl/mips_instr_mem_responder_pkg.sv
// Shared types and constants for the MIPS instruction-side responder.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_BOOT,
        ST_RUN,
        ST_HALT,
        ST_TOUT
    } resp_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] MIPS_NOP             = 32'h0;

endpackage

// File: rtl/mips_prog_buffer.sv
// Program word buffer: append-only synchronous write, combinational fetch
// with a range check against the number of words loaded so far.
module mips_prog_buffer
    import mips_tb_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   idx;
    logic          wr_fire;

    assign not_full = (wr_ptr_q < PW'(DEPTH));
    assign wr_fire  = wr_en && not_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Array is deliberately not cleared; wr_ptr bounds what fetch can see.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        idx     = (rd_addr - RESET_VECTOR) >> 2;
        rd_hit  = (rd_addr[1:0] == 2'b00) && (idx < {{(32-PW){1'b0}}, wr_ptr_q});
        rd_data = rd_hit ? mem_q[idx[AW-1:0]] : MIPS_NOP;
    end

endmodule

// File: rtl/mips_instr_mem_responder.sv
// Loads a program, sequences CPU reset/enable, serves instruction fetches and
// reports halt (fetch from 0) or timeout along with the captured $v0.
module mips_instr_mem_responder
    import mips_tb_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter int          MAX_CYCLES   = 1024,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_word,
    output logic        load_ready,
    input  logic        start,
    output logic        cpu_reset,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] register_v0,
    output logic        done,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] result,
    output logic        fetch_fault
);

    localparam int CW = $clog2(MAX_CYCLES) + 1;

    resp_state_t   state_q, state_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0]   result_q, result_d;
    logic          fault_q, fault_d;
    logic          buf_not_full;
    logic          rd_hit;
    logic          in_load;

    assign in_load    = (state_q == ST_LOAD);
    assign load_ready = in_load && buf_not_full;

    mips_prog_buffer #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (load_valid && in_load),
        .wr_data  (load_word),
        .rd_addr  (instr_address),
        .rd_data  (instr_readdata),
        .rd_hit   (rd_hit),
        .not_full (buf_not_full)
    );

    always_comb begin
        state_d        = state_q;
        cycle_cnt_d    = cycle_cnt_q;
        result_d       = result_q;
        fault_d        = fault_q;
        cpu_reset      = 1'b0;
        cpu_clk_enable = 1'b0;
        done           = 1'b0;
        halted         = 1'b0;
        timeout        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cpu_reset = 1'b1;
                if (start) state_d = ST_BOOT;
            end
            // One enabled edge with reset high so the CPU's synchronous reset lands.
            ST_BOOT: begin
                cpu_reset      = 1'b1;
                cpu_clk_enable = 1'b1;
                state_d        = ST_RUN;
            end
            ST_RUN: begin
                cpu_clk_enable = 1'b1;
                cycle_cnt_d    = cycle_cnt_q + 1'b1;
                if (instr_address == 32'h0) begin
                    result_d = register_v0;
                    state_d  = ST_HALT;
                end else if (cycle_cnt_q == CW'(MAX_CYCLES - 1)) begin
                    state_d = ST_TOUT;
                end
                if (instr_address != 32'h0 && !rd_hit) fault_d = 1'b1;
            end
            ST_HALT: begin
                done   = 1'b1;
                halted = 1'b1;
            end
            ST_TOUT: begin
                done    = 1'b1;
                timeout = 1'b1;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cycle_cnt_q <= '0;
            result_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            result_q    <= result_d;
            fault_q     <= fault_d;
        end
    end

    assign result      = result_q;
    assign fetch_fault = fault_q;

endmodule
